round_add_arbiter: RTL

- Shares one 52-bit rounding carry-lookahead adder between NREQ floating-point units (e.g. FP add/sub and FP mul/fma round stages).
- Round-robin arbitration across requesters, valid/ready handshake per requester.
- Drives the adder from an issue register and captures the sum and carry-out in a result register.
- Returns each result tagged to the requester that issued it.

---
 rtl/fpu_round_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/round_add_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fpu_round_pkg.sv
// Shared types and constants for the FP rounding-adder sharing logic.
package fpu_round_pkg;
  localparam int ROUND_WIDTH = 52;
  localparam int ROUND_TAGW  = 2;

  typedef struct packed {
    logic [ROUND_WIDTH-1:0] x;
    logic [ROUND_WIDTH-1:0] y;
    logic [ROUND_TAGW-1:0]  tag;
  } round_req_t;

  typedef struct packed {
    logic [ROUND_WIDTH-1:0] sum;
    logic                   co;
    logic [ROUND_TAGW-1:0]  tag;
  } round_rsp_t;

  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over NREQ requests; combinational grant, pointer advances past the winner.
// Latency 0; when en is low no grant is issued and the pointer holds.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_any
);
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] idx;

  // Search starts at ptr and wraps; the first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (en && !gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        gnt_any  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end
endmodule

// File: rtl/round_add_arbiter.sv
// Shares one rounding adder among NREQ FP units: issue reg (S1) feeds the adder, result reg (S2) returns sum/co/tag; perf counters under ROUND_ARB_PERF_EN.
// Accept-to-rsp_valid is two edges; a stalled result holds S2, then S1, then drops req_ready for everyone.
module round_add_arbiter
  import fpu_round_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = ROUND_WIDTH,
  parameter int TAGW  = ROUND_TAGW
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_x,
  input  logic [NREQ*WIDTH-1:0] req_y,
  input  logic [NREQ*TAGW-1:0]  req_tag,
  output logic [WIDTH-1:0]      add_x,
  output logic [WIDTH-1:0]      add_y,
  input  logic [WIDTH-1:0]      add_s,
  input  logic                  add_co,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_co,
  output logic [TAGW-1:0]       rsp_tag
`ifdef ROUND_ARB_PERF_EN
  ,
  output logic [NREQ*32-1:0]    perf_grant_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);
  localparam int IDW = id_width(NREQ);

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [TAGW-1:0]  tag;
    logic [IDW-1:0]   id;
  } issue_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             co;
    logic [TAGW-1:0]  tag;
    logic [IDW-1:0]   id;
  } result_t;

  issue_t         s1_q;
  issue_t         s1_d;
  result_t        s2_q;
  logic           s1_v;
  logic           s2_v;
  logic           s2_drain;
  logic           s2_free;
  logic           s1_adv;
  logic           s1_open;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_any;

  assign s2_drain = s2_v & rsp_ready[s2_q.id];
  assign s2_free  = ~s2_v | s2_drain;
  assign s1_adv   = s1_v & s2_free;
  assign s1_open  = ~s1_v | s1_adv;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (s1_open),
    .req     (req_valid),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  // Keep the handshake quiet while reset is held, even though S1 reads as empty.
  assign req_ready = gnt & {NREQ{reset_n}};

  always_comb begin
    s1_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        s1_d.x   = req_x[i*WIDTH +: WIDTH];
        s1_d.y   = req_y[i*WIDTH +: WIDTH];
        s1_d.tag = req_tag[i*TAGW +: TAGW];
        s1_d.id  = IDW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v <= 1'b0;
      s1_q <= '0;
      s2_v <= 1'b0;
      s2_q <= '0;
    end else begin
      if (gnt_any) begin
        s1_v <= 1'b1;
        s1_q <= s1_d;
      end else if (s1_adv) begin
        s1_v <= 1'b0;
      end
      if (s1_adv) begin
        s2_v       <= 1'b1;
        s2_q.sum   <= add_s;
        s2_q.co    <= add_co;
        s2_q.tag   <= s1_q.tag;
        s2_q.id    <= s1_q.id;
      end else if (s2_drain) begin
        s2_v <= 1'b0;
      end
    end
  end

  assign add_x   = s1_q.x;
  assign add_y   = s1_q.y;
  assign rsp_sum = s2_q.sum;
  assign rsp_co  = s2_q.co;
  assign rsp_tag = s2_q.tag;

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = s2_v && (s2_q.id == IDW'(i));
    end
  end

`ifdef ROUND_ARB_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_grant_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          perf_grant_cnt[i*32 +: 32] <= perf_grant_cnt[i*32 +: 32] + 32'd1;
        end
      end
      if ((|req_valid) && !(|req_ready)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif
endmodule
